// File: rtl/mod_inv.sv
// Iterative modular inverter: r = a^-1 mod p via binary extended Euclid, one step per clock.
// Shares the enable/done handshake of the ModAdd/ModMul stages so it chains directly.
module mod_inv #(
    parameter int unsigned      width = 32,
    parameter logic [width-1:0] p     = width'(37)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] a,
    input  logic             enable,
    output logic [width-1:0] r,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [width-1:0] u_q, v_q, x1_q, x2_q;
    logic [width-1:0] r_q;
    logic             done_q, err_q;

    logic [width-1:0] a_mod;
    logic [width-1:0] x1_half, x2_half, x1_sub, x2_sub;

    // x/2 mod p: an odd x is made even by adding p before the shift.
    function automatic logic [width-1:0] half_mod(input logic [width-1:0] x);
        logic [width:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, p}) : {1'b0, x};
        return width'(s >> 1);
    endfunction

    function automatic logic [width-1:0] sub_mod(input logic [width-1:0] x,
                                                 input logic [width-1:0] y);
        logic [width:0] s;
        s = (x >= y) ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, p} - {1'b0, y});
        return width'(s);
    endfunction

    always_comb begin
        a_mod   = a % p;
        x1_half = half_mod(x1_q);
        x2_half = half_mod(x2_q);
        x1_sub  = sub_mod(x1_q, x2_q);
        x2_sub  = sub_mod(x2_q, x1_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            u_q     <= '0;
            v_q     <= '0;
            x1_q    <= '0;
            x2_q    <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (enable) begin
                        u_q  <= a_mod;
                        v_q  <= p;
                        x1_q <= width'(1);
                        x2_q <= '0;
                        if (a_mod == '0) begin
                            r_q     <= '0;
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    // Dropping enable mid-run aborts without touching r.
                    if (!enable) begin
                        state_q <= StIdle;
                    end else if (u_q == width'(1)) begin
                        r_q     <= x1_q;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (v_q == width'(1)) begin
                        r_q     <= x2_q;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else if (!u_q[0]) begin
                        u_q  <= u_q >> 1;
                        x1_q <= x1_half;
                    end else if (!v_q[0]) begin
                        v_q  <= v_q >> 1;
                        x2_q <= x2_half;
                    end else if (u_q >= v_q) begin
                        u_q  <= u_q - v_q;
                        x1_q <= x1_sub;
                    end else begin
                        v_q  <= v_q - u_q;
                        x2_q <= x2_sub;
                    end
                end
                StDone: begin
                    if (!enable) begin
                        state_q <= StIdle;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign r    = r_q;
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_mod_inv.sv
// Self-checking bench for mod_inv: directed table at p=37, handshake corners,
// and randomized operands checked against an extended-Euclid reference model.
module tb_mod_inv;

    localparam int unsigned   W1 = 32;
    localparam logic [31:0]   P1 = 32'd37;
    localparam int unsigned   W2 = 33;
    localparam logic [32:0]   P2 = 33'd4294967291;
    localparam int            LAT_BOUND37 = 14;
    localparam int            BUDGET = 400;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   a37;
    logic          en37;
    logic [31:0]   r37;
    logic          done37, err37;
    logic [32:0]   abig;
    logic          enbig;
    logic [32:0]   rbig;
    logic          donebig, errbig;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mod_inv #(.width(W1), .p(P1)) dut37 (
        .clk(clk), .reset(reset), .a(a37), .enable(en37),
        .r(r37), .done(done37), .err(err37)
    );

    mod_inv #(.width(W2), .p(P2)) dutbig (
        .clk(clk), .reset(reset), .a(abig), .enable(enbig),
        .r(rbig), .done(donebig), .err(errbig)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] r;
        logic        err;
        int          lat;   // 0: only the latency bound is checked
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Modular inverse by the classical extended Euclidean algorithm.
    function automatic longint modinv(input longint x, input longint m);
        longint t, nt, rr, nr, q, tmp;
        t = 0; nt = 1; rr = m; nr = x;
        while (nr != 0) begin
            q   = rr / nr;
            tmp = t - q * nt;  t  = nt; nt = tmp;
            tmp = rr - q * nr; rr = nr; nr = tmp;
        end
        if (t < 0) t += m;
        return t;
    endfunction

    // Latency counts the enable-sampling edge as cycle 1; a is scrambled after it.
    task automatic op37(input logic [31:0] av, output int lat, output bit ok);
        @(negedge clk);
        a37 = av;
        en37 = 1'b1;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (i == 0) a37 = $urandom;
            if (done37) ok = 1'b1;
        end
    endtask

    task automatic release37();
        @(negedge clk);
        en37 = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic opbig(input logic [32:0] av, output int lat, output bit ok);
        @(negedge clk);
        abig = av;
        enbig = 1'b1;
        lat = 0;
        ok = 1'b0;
        for (int i = 0; i < BUDGET && !ok; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (i == 0) abig = {1'b0, $urandom};
            if (donebig) ok = 1'b1;
        end
        @(negedge clk);
        enbig = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int    lat;
        bit    ok;
        bit    stable;
        logic [31:0] last_r;
        logic [31:0] av;
        logic [32:0] bv;
        longint      exp;

        vecs[0] = '{32'd3,  32'd25, 1'b0, 0};
        vecs[1] = '{32'd1,  32'd1,  1'b0, 2};
        vecs[2] = '{32'd36, 32'd36, 1'b0, 0};
        vecs[3] = '{32'd0,  32'd0,  1'b1, 1};
        vecs[4] = '{32'd74, 32'd0,  1'b1, 1};
        vecs[5] = '{32'd40, 32'd25, 1'b0, 0};
        vecs[6] = '{32'd10, 32'd26, 1'b0, 0};
        vecs[7] = '{32'd2,  32'd19, 1'b0, 0};

        reset = 1'b1;
        en37 = 1'b0;
        enbig = 1'b0;
        a37 = '0;
        abig = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_r", r37, 0);
        check("reset_done", done37, 0);
        check("reset_err", err37, 0);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[k]) begin
            op37(vecs[k].a, lat, ok);
            check("table_timeout", ok, 1);
            check("table_r", r37, vecs[k].r);
            check("table_err", err37, vecs[k].err);
            if (vecs[k].lat != 0) check("table_lat", lat, vecs[k].lat);
            else check("table_lat_bound", lat <= LAT_BOUND37, 1);
            stable = 1'b1;
            repeat (5) begin
                @(posedge clk);
                #1;
                if (!done37 || r37 !== vecs[k].r || err37 !== vecs[k].err) stable = 1'b0;
            end
            check("table_hold", stable, 1);
            release37();
            check("release_done", done37, 0);
            check("release_err", err37, 0);
            check("release_r", r37, vecs[k].r);
        end
        last_r = vecs[7].r;

        // Abort: drop enable two cycles after the start edge.
        @(negedge clk);
        a37 = 32'd10;
        en37 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_run_done", done37, 0);
        @(posedge clk);
        @(negedge clk);
        en37 = 1'b0;
        stable = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done37 || r37 !== last_r) stable = 1'b0;
        end
        check("abort_hold", stable, 1);

        // Reset while holding an error result.
        op37(32'd0, lat, ok);
        check("zero_err", err37, 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_done_clr_done", done37, 0);
        check("reset_done_clr_err", err37, 0);
        @(negedge clk);
        reset = 1'b0;
        en37 = 1'b0;

        // Reset mid-run after a nonzero result.
        op37(32'd3, lat, ok);
        check("pre_reset_r", r37, 25);
        release37();
        @(negedge clk);
        a37 = 32'd25;
        en37 = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        en37 = 1'b0;
        @(posedge clk);
        #1;
        check("midrun_reset_r", r37, 0);
        check("midrun_reset_done", done37, 0);
        check("midrun_reset_err", err37, 0);
        @(negedge clk);
        reset = 1'b0;

        for (int i = 1; i < 37; i++) begin
            op37(32'(i), lat, ok);
            check("sweep_timeout", ok, 1);
            check("sweep_r", r37, 64'(modinv(longint'(i), 37)));
            check("sweep_err", err37, 0);
            check("sweep_lat_bound", lat <= LAT_BOUND37, 1);
            release37();
        end

        for (int i = 0; i < 8; i++) begin
            av = $urandom;
            op37(av, lat, ok);
            check("rand37_timeout", ok, 1);
            if (av % 37 == 0) begin
                check("rand37_err", err37, 1);
                check("rand37_r", r37, 0);
            end else begin
                check("rand37_err", err37, 0);
                check("rand37_r", r37, 64'(modinv(longint'(av % 37), 37)));
            end
            release37();
        end

        for (int i = 0; i < 16; i++) begin
            bv = {1'($urandom_range(0, 1)), $urandom};
            if (i == 0) bv = P2 + 33'd1;
            if (i == 1) bv = P2;
            opbig(bv, lat, ok);
            check("big_timeout", ok, 1);
            exp = longint'(bv) % longint'(P2);
            if (exp == 0) begin
                check("big_err", errbig, 1);
                check("big_r", rbig, 0);
            end else begin
                check("big_err", errbig, 0);
                check("big_r", rbig, 64'(modinv(exp, longint'(P2))));
            end
            @(posedge clk);
            #1;
            check("big_release_done", donebig, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
